register_transfer_sequencer: RTL and testbench

REGISTER_TRANSFER_SEQUENCER -- requirements
Module: register_transfer_sequencer

---
 rtl/register_transfer_sequencer_pkg.sv | 23 ++
 rtl/register_transfer_sequencer.sv | 173 +++++++++++++++++
 tb/tb_register_transfer_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/register_transfer_sequencer_pkg.sv
// Shared definitions for the register-transfer sequencer and the register file it drives:
// default widths, command opcodes and sequencer state encoding.
package register_transfer_sequencer_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 6;
    localparam int SEL_W_DEF  = 2;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_MOVE  = 2'd1,
        OP_STORE = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/register_transfer_sequencer.sv
// Command-driven sequencer that runs LOAD/MOVE/STORE transfers against a register file
// through a one-cycle read phase and a one-cycle write phase, then hands back a response.
module register_transfer_sequencer
    import register_transfer_sequencer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int SEL_W  = SEL_W_DEF
) (
    input  logic              sequencer_clock,
    input  logic              sequencer_reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [SEL_W-1:0]  cmd_src,
    input  logic [SEL_W-1:0]  cmd_dst,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] sequencer_register_addr,
    output logic [DATA_W-1:0] sequencer_bus_output,
    output logic              sequencer_input_en,
    output logic              sequencer_out_en,
    input  logic [DATA_W-1:0] sequencer_bus_readback
);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [SEL_W-1:0]   src_q, src_d;
    logic [SEL_W-1:0]   dst_q, dst_d;
    logic [DATA_W-1:0]  imm_q, imm_d;
    logic [DATA_W-1:0]  hold_q, hold_d;

    logic               cmd_ready_q, cmd_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  bus_out_q, bus_out_d;
    logic               input_en_q, input_en_d;
    logic               out_en_q, out_en_d;

    // Next-state logic: command capture, read-data capture and phase sequencing
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src_d   = src_q;
        dst_d   = dst_q;
        imm_d   = imm_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d  = op_e'(cmd_op);
                    src_d = cmd_src;
                    dst_d = cmd_dst;
                    imm_d = cmd_imm;
                    case (op_e'(cmd_op))
                        OP_LOAD:           state_d = ST_WRITE;
                        OP_MOVE, OP_STORE: state_d = ST_READ;
                        default:           state_d = ST_DONE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                hold_d = sequencer_bus_readback;
                if (op_q == OP_MOVE) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_WRITE: state_d = ST_DONE;
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every port comes straight from a flop
    always_comb begin
        cmd_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = {DATA_W{1'b0}};
        addr_d      = {ADDR_W{1'b0}};
        bus_out_d   = {DATA_W{1'b0}};
        input_en_d  = 1'b0;
        out_en_d    = 1'b0;
        case (state_d)
            ST_IDLE: cmd_ready_d = 1'b1;
            ST_READ: begin
                out_en_d = 1'b1;
                addr_d   = ADDR_W'(src_d);
            end
            ST_WRITE: begin
                input_en_d = 1'b1;
                addr_d     = ADDR_W'(dst_d);
                if (op_d == OP_LOAD) begin
                    bus_out_d = imm_d;
                end else begin
                    bus_out_d = hold_d;
                end
            end
            ST_DONE: begin
                rsp_valid_d = 1'b1;
                case (op_d)
                    OP_LOAD:           rsp_data_d = imm_d;
                    OP_MOVE, OP_STORE: rsp_data_d = hold_d;
                    default: begin
                        rsp_data_d = {DATA_W{1'b0}};
                        rsp_err_d  = 1'b1;
                    end
                endcase
            end
            default: cmd_ready_d = 1'b0;
        endcase
    end

    // State, latched command fields and registered outputs
    always_ff @(posedge sequencer_clock) begin
        if (!sequencer_reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_LOAD;
            src_q       <= {SEL_W{1'b0}};
            dst_q       <= {SEL_W{1'b0}};
            imm_q       <= {DATA_W{1'b0}};
            hold_q      <= {DATA_W{1'b0}};
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= {DATA_W{1'b0}};
            addr_q      <= {ADDR_W{1'b0}};
            bus_out_q   <= {DATA_W{1'b0}};
            input_en_q  <= 1'b0;
            out_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            imm_q       <= imm_d;
            hold_q      <= hold_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            addr_q      <= addr_d;
            bus_out_q   <= bus_out_d;
            input_en_q  <= input_en_d;
            out_en_q    <= out_en_d;
        end
    end

    assign cmd_ready               = cmd_ready_q;
    assign rsp_valid               = rsp_valid_q;
    assign rsp_err                 = rsp_err_q;
    assign rsp_data                = rsp_data_q;
    assign sequencer_register_addr = addr_q;
    assign sequencer_bus_output    = bus_out_q;
    assign sequencer_input_en      = input_en_q;
    assign sequencer_out_en        = out_en_q;

endmodule

// File: tb/tb_register_transfer_sequencer.sv
// Directed and randomized bench for the register-transfer sequencer with a behavioural
// four-entry register file attached to its bus.
module tb_register_transfer_sequencer;

    logic        clk = 1'b0;
    logic        sequencer_reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [1:0]  cmd_src = 2'd0;
    logic [1:0]  cmd_dst = 2'd0;
    logic [15:0] cmd_imm = 16'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [5:0]  addr;
    logic [15:0] bus_out;
    logic        input_en;
    logic        out_en;
    logic [15:0] readback;

    logic [15:0] regs [4];
    logic        rf_clr = 1'b1;
    int          viol = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    register_transfer_sequencer dut (
        .sequencer_clock         (clk),
        .sequencer_reset         (sequencer_reset),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_op                  (cmd_op),
        .cmd_src                 (cmd_src),
        .cmd_dst                 (cmd_dst),
        .cmd_imm                 (cmd_imm),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_data                (rsp_data),
        .rsp_err                 (rsp_err),
        .sequencer_register_addr (addr),
        .sequencer_bus_output    (bus_out),
        .sequencer_input_en      (input_en),
        .sequencer_out_en        (out_en),
        .sequencer_bus_readback  (readback)
    );

    // Behavioural register file on the sequencer bus
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 4; i++) regs[i] <= 16'h0;
        end else if (input_en) begin
            regs[addr[1:0]] <= bus_out;
        end
    end
    assign readback = out_en ? regs[addr[1:0]] : 16'h0;

    // Bus-rule monitor: exclusive enables, quiet bus when idle, no out-of-range address
    always @(negedge clk) begin
        if ((input_en && out_en) ||
            (!input_en && !out_en && (addr != 6'd0 || bus_out != 16'h0)) ||
            (addr[5:2] != 4'd0))
            viol <= viol + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one command from a negedge, record what happens per cycle after accept
    task automatic run_cmd(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                           input logic [15:0] imm, input int hold,
                           output int t_rd, output int t_wr, output int t_rsp,
                           output logic [5:0] rd_addr, output logic [5:0] wr_addr,
                           output logic [15:0] wr_data, output logic [15:0] rsp_d,
                           output logic rsp_e, output logic stable, output logic idle_ok);
        int  w;
        bit  done;
        t_rd = -1; t_wr = -1; t_rsp = -1;
        rd_addr = 6'd0; wr_addr = 6'd0; wr_data = 16'h0; rsp_d = 16'h0; rsp_e = 1'b0;
        stable = 1'b1; idle_ok = 1'b0; done = 1'b0;
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_imm = imm;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 1; k <= 30 && !done; k++) begin
            if (out_en && t_rd < 0) begin
                t_rd = k; rd_addr = addr;
            end
            if (input_en && t_wr < 0) begin
                t_wr = k; wr_addr = addr; wr_data = bus_out;
            end
            if (rsp_valid) begin
                if (t_rsp < 0) begin
                    t_rsp = k; rsp_d = rsp_data; rsp_e = rsp_err;
                end else if (rsp_data !== rsp_d || rsp_err !== rsp_e) begin
                    stable = 1'b0;
                end
                if (cmd_ready) stable = 1'b0;
                if (k - t_rsp >= hold) begin
                    rsp_ready = 1'b1;
                    @(negedge clk);
                    rsp_ready = 1'b0;
                    idle_ok = cmd_ready && !rsp_valid;
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end else begin
                @(negedge clk);
            end
        end
    endtask

    typedef struct {
        logic [1:0]  op, src, dst;
        logic [15:0] imm;
        int          hold;
        int          e_trd, e_twr, e_trsp;
        logic [5:0]  e_raddr, e_waddr;
        logic [15:0] e_wdata, e_rsp;
        logic        e_err;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int          t_rd, t_wr, t_rsp, infl, rsps;
        logic [5:0]  ra, wa;
        logic [15:0] wd, rd, m [4];
        logic        re, st, io;
        logic [1:0]  op, src, dst;
        logic [15:0] imm;

        vecs[0] = '{2'd0, 2'd0, 2'd2, 16'hBEEF, 0, -1,  1, 2, 6'd0, 6'd2, 16'hBEEF, 16'hBEEF, 1'b0};
        vecs[1] = '{2'd0, 2'd0, 2'd1, 16'h1234, 0, -1,  1, 2, 6'd0, 6'd1, 16'h1234, 16'h1234, 1'b0};
        vecs[2] = '{2'd0, 2'd3, 2'd0, 16'hA5A5, 1, -1,  1, 2, 6'd0, 6'd0, 16'hA5A5, 16'hA5A5, 1'b0};
        vecs[3] = '{2'd1, 2'd1, 2'd3, 16'h5555, 0,  1,  2, 3, 6'd1, 6'd3, 16'h1234, 16'h1234, 1'b0};
        vecs[4] = '{2'd2, 2'd0, 2'd1, 16'h7777, 5,  1, -1, 2, 6'd0, 6'd0, 16'h0000, 16'hA5A5, 1'b0};
        vecs[5] = '{2'd3, 2'd1, 2'd2, 16'hFFFF, 0, -1, -1, 1, 6'd0, 6'd0, 16'h0000, 16'h0000, 1'b1};
        vecs[6] = '{2'd1, 2'd2, 2'd2, 16'h0F0F, 0,  1,  2, 3, 6'd2, 6'd2, 16'hBEEF, 16'hBEEF, 1'b0};
        vecs[7] = '{2'd2, 2'd3, 2'd0, 16'h1111, 0,  1, -1, 2, 6'd3, 6'd0, 16'h0000, 16'h1234, 1'b0};
        vecs[8] = '{2'd2, 2'd2, 2'd3, 16'h2222, 2,  1, -1, 2, 6'd2, 6'd0, 16'h0000, 16'hBEEF, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset enables", {30'd0, input_en, out_en}, 32'd0);
        chk("reset addr/bus", {10'd0, addr, bus_out}, 32'd0);
        chk("reset rsp_data/err", {15'd0, rsp_err, rsp_data}, 32'd0);
        sequencer_reset = 1'b1;
        rf_clr = 1'b0;
        @(negedge clk);
        chk("cmd_ready after reset", {31'd0, cmd_ready}, 32'd1);

        // Table-driven command vectors
        for (int i = 0; i < 9; i++) begin
            run_cmd(vecs[i].op, vecs[i].src, vecs[i].dst, vecs[i].imm, vecs[i].hold,
                    t_rd, t_wr, t_rsp, ra, wa, wd, rd, re, st, io);
            chk($sformatf("v%0d read cycle", i), t_rd, vecs[i].e_trd);
            chk($sformatf("v%0d write cycle", i), t_wr, vecs[i].e_twr);
            chk($sformatf("v%0d rsp cycle", i), t_rsp, vecs[i].e_trsp);
            chk($sformatf("v%0d read addr", i), {26'd0, ra}, {26'd0, vecs[i].e_raddr});
            chk($sformatf("v%0d write addr", i), {26'd0, wa}, {26'd0, vecs[i].e_waddr});
            chk($sformatf("v%0d write data", i), {16'd0, wd}, {16'd0, vecs[i].e_wdata});
            chk($sformatf("v%0d rsp_data", i), {16'd0, rd}, {16'd0, vecs[i].e_rsp});
            chk($sformatf("v%0d rsp_err", i), {31'd0, re}, {31'd0, vecs[i].e_err});
            chk($sformatf("v%0d rsp stable", i), {31'd0, st}, 32'd1);
            chk($sformatf("v%0d idle after rsp", i), {31'd0, io}, 32'd1);
        end

        // Reset during MOVE read phase: write dropped, no response
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_src = 2'd1; cmd_dst = 2'd0; cmd_imm = 16'h0;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("midreset out_en in READ", {31'd0, out_en}, 32'd1);
        sequencer_reset = 1'b0;
        @(negedge clk);
        sequencer_reset = 1'b1;
        infl = 0; rsps = 0;
        for (int k = 0; k < 5; k++) begin
            if (input_en) infl++;
            if (rsp_valid) rsps++;
            @(negedge clk);
        end
        chk("midreset input_en count", infl, 32'd0);
        chk("midreset rsp count", rsps, 32'd0);
        chk("midreset cmd_ready", {31'd0, cmd_ready}, 32'd1);
        run_cmd(2'd2, 2'd0, 2'd0, 16'h0, 0, t_rd, t_wr, t_rsp, ra, wa, wd, rd, re, st, io);
        chk("midreset reg0 untouched", {16'd0, rd}, 32'h0000A5A5);

        // Randomized commands against a register model
        m[0] = 16'hA5A5; m[1] = 16'h1234; m[2] = 16'hBEEF; m[3] = 16'h1234;
        for (int n = 0; n < 1000; n++) begin
            op  = 2'($urandom_range(0, 3));
            src = 2'($urandom_range(0, 3));
            dst = 2'($urandom_range(0, 3));
            imm = 16'($urandom);
            run_cmd(op, src, dst, imm, int'($urandom_range(0, 2)),
                    t_rd, t_wr, t_rsp, ra, wa, wd, rd, re, st, io);
            case (op)
                2'd0: m[dst] = imm;
                2'd1: m[dst] = m[src];
                2'd2: chk("random STORE data", {16'd0, rd}, {16'd0, m[src]});
                default: chk("random reserved err", {31'd0, re}, 32'd1);
            endcase
        end

        chk("bus rule violations", viol, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
